// File: rtl/matrix_accel_sequencer.sv
// Sequences one multiply-accumulate job through the matrix accelerator
// datapath: multipliers, crossbar, per-output adders, final adder.
//
// Ports:
//   Clk, Rst            clock, async active-high reset
//   cmd_*               host operand beat (valid/ready, last, direct, operands)
//   multiplier_input,
//   multiplicand_input  registered operands to the multiplier array
//   mStart / mReady     per-lane multiply start pulse / ready
//   AddressSelect,
//   direct, Add         crossbar select, direct mode, per-output add strobes
//   finalAdd /
//   finalReady,
//   finalAccumulate     final reduction start / done / sum
//   res_*               result handshake and captured result
//   busy, err, err_clr  status, sticky timeout flag and its clear
module matrix_accel_sequencer #(
  parameter int IN_PORTS  = 4,
  parameter int OUT_PORTS = 4,
  parameter int BIT_LEN   = 32,
  parameter int ADDR_LEN  = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_last,
  input  logic                          cmd_direct,
  input  logic [IN_PORTS*BIT_LEN-1:0]   cmd_multiplier,
  input  logic [IN_PORTS*BIT_LEN-1:0]   cmd_multiplicand,
  output logic [IN_PORTS*BIT_LEN-1:0]   multiplier_input,
  output logic [IN_PORTS*BIT_LEN-1:0]   multiplicand_input,
  output logic [IN_PORTS-1:0]           mStart,
  input  logic [IN_PORTS-1:0]           mReady,
  output logic [ADDR_LEN-1:0]           AddressSelect,
  output logic                          direct,
  output logic [OUT_PORTS-1:0]          Add,
  output logic                          finalAdd,
  input  logic                          finalReady,
  input  logic [2*BIT_LEN-1:0]          finalAccumulate,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*BIT_LEN-1:0]          res_data,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(2 * OUT_PORTS);

  typedef enum logic [2:0] {
    IDLE, LOAD, MWAIT, ROUTE, FINAL, FWAIT, DONE
  } state_t;

  state_t              state;
  logic [IN_PORTS-1:0] done_q;
  logic [CW-1:0]       tcnt;
  logic [RW-1:0]       rcnt;
  logic                last_q;
  logic                dir_q;

  logic [IN_PORTS-1:0] done_nx;
  logic                tmo;
  logic [RW-1:0]       rnx;
  logic [RW-1:0]       rlast;

  // lanes may report on different cycles, so ready is accumulated
  assign done_nx = done_q | mReady;
  assign tmo     = (tcnt >= CW'(TIMEOUT - 1));
  assign rnx     = rcnt + RW'(1);
  // ROUTE cycle index: even = select set up, odd = registered xbar out valid
  assign rlast   = dir_q ? RW'(1) : RW'(2 * OUT_PORTS - 1);
  assign busy    = (state != IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state              <= IDLE;
      cmd_ready          <= 1'b0;
      multiplier_input   <= '0;
      multiplicand_input <= '0;
      mStart             <= '0;
      AddressSelect      <= '0;
      direct             <= 1'b0;
      Add                <= '0;
      finalAdd           <= 1'b0;
      res_valid          <= 1'b0;
      res_data           <= '0;
      err                <= 1'b0;
      done_q             <= '0;
      tcnt               <= '0;
      rcnt               <= '0;
      last_q             <= 1'b0;
      dir_q              <= 1'b0;
    end else begin
      mStart   <= '0;
      Add      <= '0;
      finalAdd <= 1'b0;
      // a timeout later in this block overrides the clear
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            multiplier_input   <= cmd_multiplier;
            multiplicand_input <= cmd_multiplicand;
            last_q             <= cmd_last;
            dir_q              <= cmd_direct;
            mStart             <= '1;
            cmd_ready          <= 1'b0;
            state              <= LOAD;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          done_q <= '0;
          tcnt   <= '0;
          state  <= MWAIT;
        end
        MWAIT: begin
          done_q <= done_nx;
          if (&done_nx) begin
            rcnt          <= '0;
            direct        <= dir_q;
            AddressSelect <= '0;
            state         <= ROUTE;
          end else if (tmo) begin
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (tcnt != CW'(TIMEOUT)) begin
            tcnt <= tcnt + CW'(1);
          end
        end
        ROUTE: begin
          if (rcnt == rlast) begin
            direct        <= 1'b0;
            AddressSelect <= '0;
            if (last_q) begin
              finalAdd <= 1'b1;
              state    <= FINAL;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            rcnt <= rnx;
            if (dir_q) begin
              Add <= '1;
            end else begin
              AddressSelect <= ADDR_LEN'(rnx >> 1);
              if (rnx[0]) Add <= OUT_PORTS'(1) << (rnx >> 1);
            end
          end
        end
        FINAL: begin
          tcnt  <= '0;
          state <= FWAIT;
        end
        FWAIT: begin
          if (finalReady) begin
            res_data  <= finalAccumulate;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (tmo) begin
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (tcnt != CW'(TIMEOUT)) begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_accel_sequencer.sv
// Bench for matrix_accel_sequencer: a per-cycle schedule of stimulus and
// expected outputs is planned from job-level timing rules, then replayed.
module tb_matrix_accel_sequencer;
  localparam int IP = 4, OP = 4, BL = 32, AL = 2, TO = 15, NC = 3000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic cmd_valid, cmd_ready, cmd_last, cmd_direct;
  logic [IP*BL-1:0] cmd_multiplier, cmd_multiplicand;
  logic [IP*BL-1:0] multiplier_input, multiplicand_input;
  logic [IP-1:0] mStart, mReady;
  logic [AL-1:0] AddressSelect;
  logic direct;
  logic [OP-1:0] Add;
  logic finalAdd, finalReady;
  logic [2*BL-1:0] finalAccumulate, res_data;
  logic res_valid, res_ready, busy, err, err_clr;

  matrix_accel_sequencer #(
    .IN_PORTS(IP), .OUT_PORTS(OP), .BIT_LEN(BL),
    .ADDR_LEN(AL), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_last(cmd_last), .cmd_direct(cmd_direct),
    .cmd_multiplier(cmd_multiplier),
    .cmd_multiplicand(cmd_multiplicand),
    .multiplier_input(multiplier_input),
    .multiplicand_input(multiplicand_input),
    .mStart(mStart), .mReady(mReady),
    .AddressSelect(AddressSelect), .direct(direct), .Add(Add),
    .finalAdd(finalAdd), .finalReady(finalReady),
    .finalAccumulate(finalAccumulate),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 Clk = ~Clk;

  // stimulus schedule
  logic           s_valid [NC];
  logic           s_last  [NC];
  logic           s_dir   [NC];
  logic [127:0]   s_mul   [NC];
  logic [127:0]   s_mcd   [NC];
  logic [IP-1:0]  s_mrdy  [NC];
  logic           s_frdy  [NC];
  logic [63:0]    s_facc  [NC];
  logic           s_rrdy  [NC];
  logic           s_clr   [NC];
  // expected schedule
  logic           e_crdy  [NC];
  logic [IP-1:0]  e_mst   [NC];
  logic [AL-1:0]  e_addr  [NC];
  logic           e_dir   [NC];
  logic [OP-1:0]  e_add   [NC];
  logic           e_fadd  [NC];
  logic           e_rv    [NC];
  logic [63:0]    e_rd    [NC];
  logic           e_busy  [NC];
  logic           e_err   [NC];
  logic [127:0]   e_mul   [NC];
  logic [127:0]   e_mcd   [NC];
  // events feeding the carried values
  logic           set_op  [NC];
  logic [127:0]   op_m    [NC];
  logic [127:0]   op_c    [NC];
  logic           set_rd  [NC];
  logic [63:0]    rd_v    [NC];
  logic           to_set  [NC];

  int cur;
  int fw_start;
  int nend;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int c,
                     input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, exp);
    end
  endtask

  // Plan one beat starting from the first IDLE cycle 'cur'.
  // d*: lane ready delay after mStart (-1 = never); fd: FWAIT cycles
  // before finalReady; bp: DONE cycles with res_ready low.
  task automatic plan_beat(input int gap, input bit lst, input bit dr,
                           input int d0, input int d1, input int d2,
                           input int d3, input int fd, input int bp,
                           input logic [63:0] x, input bit clr_to);
    int d[IP];
    int v, a, ld, mx, r, n, f, q, t;
    bit hang;
    logic [127:0] m, k;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    m = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    v = cur + gap;
    a = (v > cur) ? v : cur;
    for (int c = v; c <= a; c++) begin
      s_valid[c] = 1'b1; s_last[c] = lst; s_dir[c] = dr;
      s_mul[c] = m; s_mcd[c] = k;
    end
    for (int c = cur; c <= a; c++) e_crdy[c] = 1'b1;
    ld = a + 1;
    set_op[ld] = 1'b1; op_m[ld] = m; op_c[ld] = k;
    e_mst[ld] = '1; e_busy[ld] = 1'b1;
    hang = 1'b0; mx = 0;
    for (int i = 0; i < IP; i++) begin
      if (d[i] < 1 || d[i] > TO) hang = 1'b1;
      else begin
        s_mrdy[ld + d[i]][i] = 1'b1;
        if (d[i] > mx) mx = d[i];
      end
    end
    if (hang) begin
      t = ld + TO;
      for (int c = ld + 1; c <= t; c++) e_busy[c] = 1'b1;
      to_set[t] = 1'b1;
      if (clr_to) s_clr[t] = 1'b1;
      cur = t + 1;
      return;
    end
    for (int c = ld + 1; c <= ld + mx; c++) e_busy[c] = 1'b1;
    r = ld + mx + 1;
    n = dr ? 2 : 2 * OP;
    for (int j = 0; j < n; j++) begin
      e_busy[r + j] = 1'b1;
      e_dir[r + j] = dr;
      if (dr) begin
        if (j == 1) e_add[r + j] = '1;
      end else begin
        e_addr[r + j] = AL'(j / 2);
        if (j % 2 == 1) e_add[r + j] = OP'(1) << (j / 2);
      end
    end
    if (!lst) begin
      cur = r + n;
      return;
    end
    f = r + n;
    e_fadd[f] = 1'b1; e_busy[f] = 1'b1;
    fw_start = f + 1;
    if (fd >= TO) begin
      t = f + TO;
      for (int c = f + 1; c <= t; c++) e_busy[c] = 1'b1;
      to_set[t] = 1'b1;
      cur = t + 1;
      return;
    end
    for (int c = f + 1; c <= f + 1 + fd; c++) e_busy[c] = 1'b1;
    s_frdy[f + 1 + fd] = 1'b1;
    s_facc[f + 1 + fd] = x;
    q = f + 2 + fd;
    set_rd[q] = 1'b1; rd_v[q] = x;
    for (int j = 0; j <= bp; j++) begin
      e_rv[q + j] = 1'b1; e_busy[q + j] = 1'b1;
      s_rrdy[q + j] = (j == bp);
    end
    cur = q + bp + 1;
  endtask

  task automatic check_all_zero(input string tag, input int c);
    chk({tag, "_cmd_ready"}, c, 128'(cmd_ready), 0);
    chk({tag, "_busy"}, c, 128'(busy), 0);
    chk({tag, "_mStart"}, c, 128'(mStart), 0);
    chk({tag, "_Add"}, c, 128'(Add), 0);
    chk({tag, "_addr"}, c, 128'(AddressSelect), 0);
    chk({tag, "_direct"}, c, 128'(direct), 0);
    chk({tag, "_finalAdd"}, c, 128'(finalAdd), 0);
    chk({tag, "_res_valid"}, c, 128'(res_valid), 0);
    chk({tag, "_res_data"}, c, 128'(res_data), 0);
    chk({tag, "_err"}, c, 128'(err), 0);
    chk({tag, "_mul_in"}, c, multiplier_input, 0);
    chk({tag, "_mcd_in"}, c, multiplicand_input, 0);
  endtask

  initial begin
    int nb, rs, g, fdv;
    int dd[IP];
    cmd_valid = 0; cmd_last = 0; cmd_direct = 0;
    cmd_multiplier = '0; cmd_multiplicand = '0;
    mReady = '0; finalReady = 0; finalAccumulate = '0;
    res_ready = 0; err_clr = 0;

    for (int c = 0; c < NC; c++) begin
      s_valid[c] = 1'b0; s_last[c] = 1'($urandom); s_dir[c] = 1'($urandom);
      s_mul[c] = {$urandom, $urandom, $urandom, $urandom};
      s_mcd[c] = {$urandom, $urandom, $urandom, $urandom};
      s_mrdy[c] = '0; s_frdy[c] = 1'b0;
      s_facc[c] = {$urandom, $urandom};
      s_rrdy[c] = 1'($urandom); s_clr[c] = ($urandom % 6 == 0);
      e_crdy[c] = 0; e_mst[c] = '0; e_addr[c] = '0; e_dir[c] = 0;
      e_add[c] = '0; e_fadd[c] = 0; e_rv[c] = 0; e_rd[c] = '0;
      e_busy[c] = 0; e_err[c] = 0; e_mul[c] = '0; e_mcd[c] = '0;
      set_op[c] = 0; op_m[c] = '0; op_c[c] = '0;
      set_rd[c] = 0; rd_v[c] = '0; to_set[c] = 0;
    end

    cur = 0;
    plan_beat(0, 1, 0, 3, 3, 3, 3, 2, 5, 64'h0000_0000_4049_0FDB, 0);
    plan_beat(0, 0, 0, 1, 4, 4, 7, 0, 0, 64'h0, 0);
    plan_beat(1, 0, 1, 2, 2, 2, 2, 0, 0, 64'h0, 0);
    plan_beat(0, 1, 0, 1, 1, 1, 1, 3, 2, {$urandom, $urandom}, 0);
    plan_beat(0, 1, 0, 2, 2, -1, 2, 0, 0, 64'h0, 1);
    s_clr[cur + 2] = 1'b1;

    while (cur < NC - 400) begin
      nb = 1 + int'($urandom % 3);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < IP; i++) dd[i] = 1 + int'($urandom % 8);
        rs = int'($urandom % 20);
        if (rs == 0) dd[$urandom % IP] = -1;
        else if (rs == 1) dd[0] = TO;
        else if (rs < 5) for (int i = 0; i < IP; i++) dd[i] = 1;
        rs = int'($urandom % 15);
        fdv = (rs == 0) ? TO + 5 : (rs == 1) ? TO - 1 : int'($urandom % 6);
        g = int'($urandom_range(0, 5)) - 2;
        plan_beat(g, b == nb - 1, ($urandom % 4 == 0),
                  dd[0], dd[1], dd[2], dd[3], fdv,
                  int'($urandom % 4), {$urandom, $urandom}, 0);
      end
    end
    plan_beat(0, 1, 0, 2, 2, 2, 2, TO + 50, 0, 64'h0, 0);
    nend = fw_start + 3;

    for (int c = 1; c < NC; c++) begin
      e_mul[c] = set_op[c] ? op_m[c] : e_mul[c-1];
      e_mcd[c] = set_op[c] ? op_c[c] : e_mcd[c-1];
      e_rd[c]  = set_rd[c] ? rd_v[c] : e_rd[c-1];
      e_err[c] = to_set[c-1] | (!s_clr[c-1] & e_err[c-1]);
    end

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("reset", -1);
    Rst = 1'b0;

    fork
      begin
        for (int c = 0; c < nend; c++) begin
          @(posedge Clk);
          #1;
          cmd_valid = s_valid[c]; cmd_last = s_last[c];
          cmd_direct = s_dir[c];
          cmd_multiplier = s_mul[c]; cmd_multiplicand = s_mcd[c];
          mReady = s_mrdy[c]; finalReady = s_frdy[c];
          finalAccumulate = s_facc[c]; res_ready = s_rrdy[c];
          err_clr = s_clr[c];
        end
      end
      begin
        for (int c = 0; c < nend; c++) begin
          @(negedge Clk);
          chk("cmd_ready", c, 128'(cmd_ready), 128'(e_crdy[c]));
          chk("mStart", c, 128'(mStart), 128'(e_mst[c]));
          chk("AddressSelect", c, 128'(AddressSelect), 128'(e_addr[c]));
          chk("direct", c, 128'(direct), 128'(e_dir[c]));
          chk("Add", c, 128'(Add), 128'(e_add[c]));
          chk("finalAdd", c, 128'(finalAdd), 128'(e_fadd[c]));
          chk("res_valid", c, 128'(res_valid), 128'(e_rv[c]));
          chk("res_data", c, 128'(res_data), 128'(e_rd[c]));
          chk("busy", c, 128'(busy), 128'(e_busy[c]));
          chk("err", c, 128'(err), 128'(e_err[c]));
          chk("mul_in", c, multiplier_input, e_mul[c]);
          chk("mcd_in", c, multiplicand_input, e_mcd[c]);
          if (c == 6)  chk("lit_add0", c, 128'(Add), 128'(4'b0001));
          if (c == 10) chk("lit_addr2", c, 128'(AddressSelect), 128'(2));
          if (c == 12) chk("lit_add3", c, 128'(Add), 128'(4'b1000));
          if (c == 13) chk("lit_final", c, 128'(finalAdd), 128'(1));
          if (c == 17) chk("lit_res", c, 128'(res_data),
                           128'(64'h0000_0000_4049_0FDB));
          if (c == 21) chk("lit_bp_valid", c, 128'(res_valid), 128'(1));
          if (c == 23) chk("lit_idle", c, 128'(cmd_ready), 128'(1));
          if (c == 31) chk("lit_no_early", c, 128'(Add), 128'(0));
          if (c == 33) chk("lit_stagger", c, 128'(Add), 128'(4'b0001));
          if (c == 40) chk("lit_between", c, 128'(cmd_ready), 128'(1));
          if (c == 46) chk("lit_direct", c, 128'(Add), 128'(4'b1111));
          if (c == 51) chk("lit_zero_lat", c, 128'(Add), 128'(4'b0001));
        end
      end
    join

    #2;
    Rst = 1'b1;
    #1;
    check_all_zero("async_rst", nend);
    cmd_valid = 0; finalReady = 1; res_ready = 0; err_clr = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("post_rst_res_valid", nend + i, 128'(res_valid), 0);
      chk("post_rst_finalAdd", nend + i, 128'(finalAdd), 0);
      chk("post_rst_cmd_ready", nend + i, 128'(cmd_ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
